audio_sample_fifo: RTL and testbench

- Elastic sample buffer between the UART byte receiver and the I2S driver, at 27 MHz `clk`.
- Converts each received 8-bit unsigned PCM byte to a 24-bit two's-complement mono sample and stores it in a FIFO.
- Releases one sample per I2S frame request from the driver.
- Absorbs UART burst/jitter with a prefill watermark, and mutes the DAC on underrun until the buffer refills.

---
 rtl/audio_pkg.sv | 17 +
 rtl/sync_fifo_ram.sv | 28 ++
 rtl/audio_sample_fifo.sv | 145 ++++++++++++++
 tb/tb_audio_sample_fifo.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared widths, FSM state type and the PCM byte-to-sample conversion for audio_sample_fifo.
package audio_pkg;

    localparam int unsigned SAMPLE_W = 24;
    localparam int unsigned BYTE_W   = 8;

    typedef enum logic {
        PREFILL = 1'b0,
        PLAY    = 1'b1
    } state_t;

    // Offset-binary byte to two's-complement 24-bit sample, left-justified.
    function automatic logic [SAMPLE_W-1:0] u8_to_s24(input logic [BYTE_W-1:0] b);
        return {~b[7], b[6:0], 16'h0000};
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage array: one write port, one read port with a registered output.
// No reset on the array or read register so that block RAM can be inferred.
module sync_fifo_ram #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned WIDTH = 24,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/audio_sample_fifo.sv
// Elastic UART-to-I2S sample buffer with prefill watermark and underrun mute.
// Read latency is 2 cycles (synchronous RAM read + output register). Optional counters: AUDIO_FIFO_STATS_EN.
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned PREFILL = 256,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BYTE_W-1:0]   byte_in,
    input  logic                byte_valid,
    input  logic                sample_req,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                mute,
    output logic [AW:0]         level,
`ifdef AUDIO_FIFO_STATS_EN
    output logic [15:0]         ovr_count,
    output logic [15:0]         udr_count,
`endif
    output logic                overrun,
    output logic                underrun
);

    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] LVL_FULL    = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_PREFILL = LW'(PREFILL);

    state_t state;
    state_t state_next;

    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                wr_fire;
    logic                rd_fire;
    logic                drop;
    logic                starve;
    logic                rd_pend;
    logic                udr_pend;
    logic [SAMPLE_W-1:0] rd_data;

    sync_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_addr (wr_ptr),
        .wr_data (u8_to_s24(byte_in)),
        .rd_en   (rd_fire),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // Next state and per-cycle write/read/drop/starve decisions.
    always_comb begin
        state_next = state;
        rd_fire    = 1'b0;
        starve     = 1'b0;
        wr_fire    = byte_valid && (level != LVL_FULL);
        drop       = byte_valid && (level == LVL_FULL);
        case (state)
            audio_pkg::PREFILL: begin
                if (level >= LVL_PREFILL) begin
                    state_next = audio_pkg::PLAY;
                end
            end
            audio_pkg::PLAY: begin
                if (sample_req) begin
                    if (level != '0) begin
                        rd_fire = 1'b1;
                    end else begin
                        starve     = 1'b1;
                        state_next = audio_pkg::PREFILL;
                    end
                end
            end
            default: state_next = audio_pkg::PREFILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= audio_pkg::PREFILL;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            rd_pend      <= 1'b0;
            udr_pend     <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            mute         <= 1'b1;
            overrun      <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state <= state_next;
            if (wr_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_fire, rd_fire})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (drop) begin
                overrun <= 1'b1;
            end
            if (starve) begin
                underrun <= 1'b1;
            end
            // Second pipeline stage: RAM data (or silence on underrun) to the driver.
            rd_pend      <= rd_fire;
            udr_pend     <= starve;
            sample_valid <= rd_pend || udr_pend;
            if (rd_pend) begin
                sample_out <= rd_data;
            end else if (udr_pend) begin
                sample_out <= '0;
            end
            mute <= (state != audio_pkg::PLAY);
        end
    end

`ifdef AUDIO_FIFO_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_count <= '0;
            udr_count <= '0;
        end else begin
            if (drop && (ovr_count != 16'hFFFF)) begin
                ovr_count <= ovr_count + 16'd1;
            end
            if (starve && (udr_count != 16'hFFFF)) begin
                udr_count <= udr_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed self-checking bench for audio_sample_fifo (default DEPTH=512, PREFILL=256).
module tb_audio_sample_fifo;

    logic        clk;
    logic        rst_n;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        sample_req;
    logic [23:0] sample_out;
    logic        sample_valid;
    logic        mute;
    logic [9:0]  level;
    logic        overrun;
    logic        underrun;
`ifdef AUDIO_FIFO_STATS_EN
    logic [15:0] ovr_count;
    logic [15:0] udr_count;
`endif

    int errors;
    int checks;
    int sv_count;

    audio_sample_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .sample_req   (sample_req),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .mute         (mute),
        .level        (level),
`ifdef AUDIO_FIFO_STATS_EN
        .ovr_count    (ovr_count),
        .udr_count    (udr_count),
`endif
        .overrun      (overrun),
        .underrun     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sample_valid) sv_count++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected sample from a PCM byte, computed arithmetically.
    function automatic logic [23:0] conv(input logic [7:0] b);
        int v;
        v = (int'(b) - 128) * 65536;
        return 24'(v);
    endfunction

    task automatic push(input logic [7:0] b, input logic req);
        byte_in    = b;
        byte_valid = 1'b1;
        sample_req = req;
        @(negedge clk);
        byte_valid = 1'b0;
        sample_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic req_check(input string tag, input logic [23:0] exp);
        int lat;
        bit got;
        sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0;
        lat = 1;
        got = 1'b0;
        while (!got && lat < 6) begin
            if (sample_valid) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        if (!got) begin
            check({tag, "_timeout"}, 32'(sample_valid), 32'd1);
        end else begin
            check({tag, "_lat"}, 32'(lat), 32'd2);
            check({tag, "_data"}, 32'(sample_out), 32'(exp));
            @(negedge clk);
            check({tag, "_pulse"}, 32'(sample_valid), 32'd0);
        end
    endtask

    initial begin
        int sv0;
        logic [7:0] b;
        errors     = 0;
        checks     = 0;
        sv_count   = 0;
        rst_n      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        sample_req = 1'b0;
        idle(2);
        check("rst_level", 32'(level), 32'd0);
        check("rst_mute", 32'(mute), 32'd1);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_out", 32'(sample_out), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_udr", 32'(underrun), 32'd0);
        rst_n = 1'b1;
        idle(1);

        // Prefill: requests ignored until 256 bytes are buffered.
        sv0 = sv_count;
        for (int i = 0; i < 255; i++) push(8'h80, (i % 32) == 5);
        idle(3);
        check("pf_no_valid", 32'(sv_count - sv0), 32'd0);
        check("pf_mute", 32'(mute), 32'd1);
        check("pf_level", 32'(level), 32'd255);
        push(8'h80, 1'b0);
        idle(2);
        check("play_mute", 32'(mute), 32'd0);
        check("play_level", 32'(level), 32'd256);
        req_check("first", 24'h000000);
        check("first_level", 32'(level), 32'd255);
        for (int i = 0; i < 255; i++) req_check("drain1", 24'h000000);
        check("drain1_level", 32'(level), 32'd0);

        // Conversion corner bytes.
        push(8'hFF, 1'b0);
        push(8'h00, 1'b0);
        push(8'h81, 1'b0);
        req_check("conv_ff", 24'h7F0000);
        req_check("conv_00", 24'h800000);
        req_check("conv_81", 24'h010000);

        // Fill to full, overflow once, drain in order across the pointer wrap.
        for (int i = 0; i < 512; i++) push(8'(i), 1'b0);
        check("full_level", 32'(level), 32'd512);
        check("full_ovr0", 32'(overrun), 32'd0);
        push(8'h55, 1'b0);
        check("ovf_level", 32'(level), 32'd512);
        check("ovf_flag", 32'(overrun), 32'd1);
        for (int i = 0; i < 512; i++) begin
            b = 8'(i);
            req_check("order", conv(b));
        end
        check("empty_level", 32'(level), 32'd0);
        check("pre_udr_mute", 32'(mute), 32'd0);
        check("pre_udr_flag", 32'(underrun), 32'd0);

        // Underrun: silence, sticky flag, mute, back to prefill.
        sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0;
        check("udr_flag", 32'(underrun), 32'd1);
        @(negedge clk);
        check("udr_valid", 32'(sample_valid), 32'd1);
        check("udr_out", 32'(sample_out), 32'd0);
        check("udr_mute", 32'(mute), 32'd1);
        @(negedge clk);
        check("udr_pulse", 32'(sample_valid), 32'd0);
        sv0 = sv_count;
        push(8'h80, 1'b1);
        idle(4);
        check("refill_ignored", 32'(sv_count - sv0), 32'd0);
        check("refill_level", 32'(level), 32'd1);

        // Simultaneous write and read at level 10 and at full.
        for (int i = 0; i < 255; i++) push(8'h80, 1'b0);
        idle(2);
        check("replay_mute", 32'(mute), 32'd0);
        for (int i = 0; i < 246; i++) req_check("drain2", 24'h000000);
        check("lvl10", 32'(level), 32'd10);
        push(8'h80, 1'b1);
        idle(3);
        check("simul_lvl10", 32'(level), 32'd10);
        for (int i = 0; i < 502; i++) push(8'h80, 1'b0);
        check("refull", 32'(level), 32'd512);
        push(8'h80, 1'b1);
        idle(3);
        check("simul_full", 32'(level), 32'd511);
        check("simul_ovr", 32'(overrun), 32'd1);
        for (int i = 0; i < 211; i++) req_check("drain3", 24'h000000);
        check("lvl300", 32'(level), 32'd300);

        // Asynchronous reset mid-stream, checked before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_level", 32'(level), 32'd0);
        check("arst_mute", 32'(mute), 32'd1);
        check("arst_ovr", 32'(overrun), 32'd0);
        check("arst_udr", 32'(underrun), 32'd0);
        check("arst_valid", 32'(sample_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        check("post_rst_level", 32'(level), 32'd0);
        check("post_rst_mute", 32'(mute), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
